imem_prog: RTL and testbench
============================

Name: imem_prog

Overview:
- Parametrised, synchronous-read instruction memory; next generation of the combinational ROM `imem`.
- Adds a boot-time clear sequencer, a program-load write port, configurable read latency and an out-of-range flag.
- Sits between the testbench/loader and the fetch stage.
- Replaces the hard-coded ROM contents with contents loaded at runtime.

Parameters:
- DATA_W, 32, instruction word width.
- ADDR_W, 6, word address width; storage is 2**ADDR_W words.
- DEPTH, 47, number of valid program words; addresses >= DEPTH are out of range.
- READ_LAT, 1, read latency in cycles; legal values are 1 or 2. Any other value is an elaboration error.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- ready  out  1  high when the CLEAR sequence has finished and the block accepts requests.
- ld_en  in  1  program-load write strobe.
- ld_addr  in  ADDR_W  load word address.
- ld_data  in  DATA_W  load data.
- ld_err  out  1  one-cycle pulse: the load was rejected.
- rd_en  in  1  read request.
- rd_addr  in  ADDR_W  read word address.
- rd_data  out  DATA_W  read data.
- rd_valid  out  1  rd_data is valid this cycle.
- rd_oob  out  1  qualifies rd_valid: the read address was >= DEPTH.

Behaviour:
- Reset (reset low, asynchronous):
  - State goes to CLEAR; clr_cnt=0.
  - Outputs: ready=0, rd_valid=0, rd_oob=0, ld_err=0, rd_data=0.
  - All read-pipeline valid bits are cleared.
  - Memory contents are not reset directly.
- FSM has two states, CLEAR and RUN.
  - CLEAR: each cycle writes 0 to mem[clr_cnt], then clr_cnt++.
  - After writing word 2**ADDR_W-1, the next state is RUN. CLEAR therefore lasts exactly 2**ADDR_W cycles after reset deassertion.
  - RUN: ready=1. The FSM stays in RUN until the next reset.
- Reset asserted mid-CLEAR or mid-RUN: restart CLEAR from clr_cnt=0; in-flight reads are discarded (no rd_valid).
- Load, accepted when ld_en=1 and ready=1 and ld_addr < DEPTH:
  - mem[ld_addr] <= ld_data at the clock edge.
- Load rejected:
  - ld_en=1 with ld_addr >= DEPTH while ready=1: no write; ld_err=1 on the next cycle only.
  - ld_en=1 while ready=0: ignored silently; no write and no ld_err.
- Read request in RUN (rd_en=1, ready=1) is captured at edge N:
  - READ_LAT=1: rd_valid=1 during cycle N+1, with rd_data=mem[rd_addr].
  - READ_LAT=2: rd_valid=1 during cycle N+2; the data is registered through one extra pipeline stage.
  - Throughput is one read per cycle; back-to-back requests give back-to-back rd_valid.
- Out of range: if rd_addr >= DEPTH, then rd_data=0 and rd_oob=1 with rd_valid=1, on the same latency as a normal read.
- rd_en while ready=0: dropped; it never produces rd_valid.
- Simultaneous load and read to the same address in the same cycle: read-first. The read returns the old contents; a read one cycle later returns the new data.
- rd_valid=0 cycles:
  - rd_data holds its last value.
  - rd_oob=0.
- Width rule: ld_addr and rd_addr compare against DEPTH unsigned. DEPTH <= 2**ADDR_W is enforced at elaboration.

Test Plan:
1. Reset low 3 cycles, then high:
   - ready=0 for exactly 64 cycles, then ready=1.
   - Reads of addresses 0..63 all return 32'h0; addresses 47..63 also return rd_oob=1.
2. Load sequence:
   - Loads: addr0=32'hf8000001, addr1=32'hf8008002, addr46=32'hb400001f.
   - Read addresses 0, 1, 46 back-to-back with READ_LAT=1.
   - Expect rd_valid on 3 consecutive cycles with the same values, rd_oob=0.
3. Rejected load:
   - ld_en with ld_addr=47, ld_data=32'hdeadbeef → ld_err pulse for 1 cycle.
   - Read 47 → rd_data=0, rd_oob=1.
   - ld_en during CLEAR → no ld_err; a later read returns 0.
4. Same-cycle collision:
   - Load addr5=32'h8b050083 while reading addr5 (old value 0) → rd_data=0.
   - Reading addr5 on the next cycle → 32'h8b050083.
5. READ_LAT=2 build:
   - rd_en at edge N → rd_valid first at N+2.
   - 4 streamed reads → 4 consecutive valid cycles in request order.
6. Reset mid-RUN with 2 reads in flight:
   - No rd_valid after reset; ready=0 again for 64 cycles.
   - Previously loaded addr0 reads 32'h0 afterwards.

Source files
------------

// File: rtl/imem_prog.sv
// Runtime-loadable instruction memory: zero-fills itself after reset, then serves
// fetch reads with a 1- or 2-cycle latency and takes program-load writes.
module imem_prog #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 6,
    parameter int DEPTH    = 47,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    output logic              ready,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_err,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_oob
);

    localparam int WORDS = 2**ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);

    generate
        if (READ_LAT != 1 && READ_LAT != 2) begin : g_bad_lat
            $error("imem_prog: READ_LAT must be 1 or 2");
        end
        if (DEPTH < 1 || DEPTH > WORDS) begin : g_bad_depth
            $error("imem_prog: DEPTH must be in 1..2**ADDR_W");
        end
    endgenerate

    typedef enum logic {CLEAR, RUN} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;
    logic [DATA_W-1:0] mem [WORDS];

    logic ld_in_range, rd_in_range, ld_ok, rd_ok;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        case (state)
            CLEAR: begin
                clr_cnt_nxt = clr_cnt + 1'b1;
                if (clr_cnt == '1) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                state_nxt = RUN;
            end
            default: begin
                state_nxt = CLEAR;
            end
        endcase
    end

    assign ready       = (state == RUN);
    assign ld_in_range = ({1'b0, ld_addr} < DEPTH_V);
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_V);
    assign ld_ok       = ld_en && ready && ld_in_range;
    assign rd_ok       = rd_en && ready;

    // Storage has no reset so it maps onto RAM; the CLEAR walk zeroes it instead.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clr_cnt] <= '0;
        end else if (ld_ok) begin
            mem[ld_addr] <= ld_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ld_err <= 1'b0;
        end else begin
            ld_err <= ld_en && ready && !ld_in_range;
        end
    end

    // First read stage; sampling mem here before the write lands gives read-first.
    logic              v1, oob1;
    logic [DATA_W-1:0] d1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1   <= 1'b0;
            oob1 <= 1'b0;
            d1   <= '0;
        end else begin
            v1 <= rd_ok;
            if (rd_ok) begin
                oob1 <= !rd_in_range;
                d1   <= rd_in_range ? mem[rd_addr] : '0;
            end
        end
    end

    generate
        if (READ_LAT == 2) begin : g_lat2
            logic              v2, oob2;
            logic [DATA_W-1:0] d2;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    v2   <= 1'b0;
                    oob2 <= 1'b0;
                    d2   <= '0;
                end else begin
                    v2 <= v1;
                    if (v1) begin
                        oob2 <= oob1;
                        d2   <= d1;
                    end
                end
            end

            assign rd_valid = v2;
            assign rd_oob   = v2 && oob2;
            assign rd_data  = d2;
        end else begin : g_lat1
            assign rd_valid = v1;
            assign rd_oob   = v1 && oob1;
            assign rd_data  = d1;
        end
    endgenerate

endmodule

// File: tb/tb_imem_prog.sv
// Scoreboard bench: one READ_LAT=1 and one READ_LAT=2 instance share the same
// stimulus; per-instance monitors pop expected reads as rd_valid appears.
module tb_imem_prog;

    logic        clk;
    logic        reset;
    logic        ld_en;
    logic [5:0]  ld_addr;
    logic [31:0] ld_data;
    logic        rd_en;
    logic [5:0]  rd_addr;

    logic        ready1, ld_err1, rd_valid1, rd_oob1;
    logic [31:0] rd_data1;
    logic        ready2, ld_err2, rd_valid2, rd_oob2;
    logic [31:0] rd_data2;

    typedef struct {
        logic [31:0] data;
        logic        oob;
        int          due;
    } exp_t;

    exp_t        q1[$];
    exp_t        q2[$];
    logic [31:0] model [64];
    logic [31:0] last1, last2;
    int          cyc;
    int          n_checks;
    int          n_fail;
    logic        in_run;

    imem_prog #(.DATA_W(32), .ADDR_W(6), .DEPTH(47), .READ_LAT(1)) dut1 (
        .clk(clk), .reset(reset), .ready(ready1),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .ld_err(ld_err1),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1),
        .rd_valid(rd_valid1), .rd_oob(rd_oob1)
    );

    imem_prog #(.DATA_W(32), .ADDR_W(6), .DEPTH(47), .READ_LAT(2)) dut2 (
        .clk(clk), .reset(reset), .ready(ready2),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .ld_err(ld_err2),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data2),
        .rd_valid(rd_valid2), .rd_oob(rd_oob2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic report_fail(input string name);
        n_checks++;
        n_fail++;
        $display("[TB] FAIL %s: got event, expected none (cycle %0d)", name, cyc);
    endtask

    // Monitor for the single-cycle-latency instance.
    always @(negedge clk) begin
        exp_t e;
        if (rd_valid1) begin
            if (q1.size() == 0) begin
                report_fail("lat1 spurious rd_valid");
            end else begin
                e = q1.pop_front();
                check_output("lat1 latency", cyc, e.due);
                check_output("lat1 oob+data", {e.oob, rd_data1}, {rd_oob1, e.data});
                last1 = e.data;
            end
        end else begin
            check_output("lat1 idle hold", {rd_oob1, rd_data1}, {1'b0, last1});
            if (q1.size() > 0 && q1[0].due <= cyc) begin
                e = q1.pop_front();
                check_output("lat1 missing rd_valid", 0, 1);
            end
        end
    end

    // Monitor for the two-cycle-latency instance.
    always @(negedge clk) begin
        exp_t e;
        if (rd_valid2) begin
            if (q2.size() == 0) begin
                report_fail("lat2 spurious rd_valid");
            end else begin
                e = q2.pop_front();
                check_output("lat2 latency", cyc, e.due);
                check_output("lat2 oob+data", {e.oob, rd_data2}, {rd_oob2, e.data});
                last2 = e.data;
            end
        end else begin
            check_output("lat2 idle hold", {rd_oob2, rd_data2}, {1'b0, last2});
            if (q2.size() > 0 && q2[0].due <= cyc) begin
                e = q2.pop_front();
                check_output("lat2 missing rd_valid", {63'b0, rd_valid2}, 1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        ld_en = 1'b0;
        rd_en = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            check_output("ld_err idle", {ld_err2, ld_err1}, 2'b00);
        end
    endtask

    // Drives one cycle of load/read, records expectations read-first, then ticks.
    task automatic apply_stimulus(input logic do_ld, input logic [5:0] la, input logic [31:0] ldv,
                                  input logic do_rd, input logic [5:0] ra);
        exp_t e;
        logic exp_err;
        ld_en   = do_ld;
        ld_addr = la;
        ld_data = ldv;
        rd_en   = do_rd;
        rd_addr = ra;
        if (do_rd && in_run) begin
            e.oob  = (ra >= 6'd47);
            e.data = e.oob ? 32'h0 : model[ra];
            e.due  = cyc + 1;
            q1.push_back(e);
            e.due  = cyc + 2;
            q2.push_back(e);
        end
        exp_err = do_ld && in_run && (la >= 6'd47);
        if (do_ld && in_run && la < 6'd47) begin
            model[la] = ldv;
        end
        tick();
        check_output("ld_err", {ld_err2, ld_err1}, {exp_err, exp_err});
    endtask

    task automatic do_reset(input int hold);
        int   cnt;
        logic err_seen;
        reset  = 1'b0;
        ld_en  = 1'b0;
        rd_en  = 1'b0;
        in_run = 1'b0;
        q1.delete();
        q2.delete();
        last1  = 32'h0;
        last2  = 32'h0;
        for (int i = 0; i < 64; i++) model[i] = 32'h0;
        #1;
        check_output("reset ready", {ready2, ready1}, 2'b00);
        check_output("reset valid/oob/err", {rd_valid2, rd_valid1, rd_oob2, rd_oob1, ld_err2, ld_err1}, 6'b0);
        check_output("reset rd_data", {rd_data2, rd_data1}, 64'h0);
        repeat (hold) tick();
        reset    = 1'b1;
        cnt      = 0;
        err_seen = 1'b0;
        while (!ready1 && cnt < 200) begin
            if (cnt < 10) begin
                ld_en   = 1'b1;
                ld_addr = 6'd3;
                ld_data = 32'hffffffff;
                rd_en   = 1'b1;
                rd_addr = 6'd2;
            end else begin
                ld_en = 1'b0;
                rd_en = 1'b0;
            end
            tick();
            cnt++;
            err_seen = err_seen | ld_err1 | ld_err2;
        end
        ld_en = 1'b0;
        rd_en = 1'b0;
        check_output("clear cycles", cnt, 64);
        check_output("ld_err during clear", {63'b0, err_seen}, 0);
        check_output("ready after clear", {ready2, ready1}, 2'b11);
        in_run = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        last1    = 32'h0;
        last2    = 32'h0;
        in_run   = 1'b0;
        reset    = 1'b1;
        ld_en    = 1'b0;
        ld_addr  = 6'd0;
        ld_data  = 32'h0;
        rd_en    = 1'b0;
        rd_addr  = 6'd0;
        #1;
        $display("[TB] reset and clear");
        do_reset(3);

        $display("[TB] read all words after clear");
        for (int a = 0; a < 64; a++) apply_stimulus(1'b0, 6'd0, 32'h0, 1'b1, 6'(a));
        idle(3);

        $display("[TB] program load and readback");
        apply_stimulus(1'b1, 6'd0,  32'hf8000001, 1'b0, 6'd0);
        apply_stimulus(1'b1, 6'd1,  32'hf8008002, 1'b0, 6'd0);
        apply_stimulus(1'b1, 6'd46, 32'hb400001f, 1'b0, 6'd0);
        apply_stimulus(1'b0, 6'd0,  32'h0, 1'b1, 6'd0);
        apply_stimulus(1'b0, 6'd0,  32'h0, 1'b1, 6'd1);
        apply_stimulus(1'b0, 6'd0,  32'h0, 1'b1, 6'd46);
        idle(3);

        $display("[TB] rejected loads");
        apply_stimulus(1'b1, 6'd47, 32'hdeadbeef, 1'b0, 6'd0);
        idle(1);
        apply_stimulus(1'b0, 6'd0, 32'h0, 1'b1, 6'd47);
        apply_stimulus(1'b0, 6'd0, 32'h0, 1'b1, 6'd3);
        idle(3);

        $display("[TB] same-cycle load/read collision");
        apply_stimulus(1'b1, 6'd5, 32'h8b050083, 1'b1, 6'd5);
        apply_stimulus(1'b0, 6'd0, 32'h0,        1'b1, 6'd5);
        idle(3);

        $display("[TB] streamed reads");
        apply_stimulus(1'b0, 6'd0, 32'h0, 1'b1, 6'd0);
        apply_stimulus(1'b0, 6'd0, 32'h0, 1'b1, 6'd46);
        apply_stimulus(1'b0, 6'd0, 32'h0, 1'b1, 6'd47);
        apply_stimulus(1'b0, 6'd0, 32'h0, 1'b1, 6'd1);
        idle(4);

        $display("[TB] reset with reads in flight");
        apply_stimulus(1'b0, 6'd0, 32'h0, 1'b1, 6'd0);
        apply_stimulus(1'b0, 6'd0, 32'h0, 1'b1, 6'd1);
        do_reset(2);
        apply_stimulus(1'b0, 6'd0, 32'h0, 1'b1, 6'd0);
        idle(4);

        check_output("lat1 queue drained", q1.size(), 0);
        check_output("lat2 queue drained", q2.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
